// File: rtl/scroll_field_pkg.sv
// Shared constants for the scrolling playfield: FSM state encoding and score width.
package scroll_field_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOAD = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam int SCORE_W = 16;

endpackage

// File: rtl/scroll_field_if.sv
// Spawn handshake between a pattern generator (master) and the playfield (slave).
interface scroll_field_if #(
   parameter int COLS     = 16,
   parameter int BUF_ROWS = 16
) ();

   logic                     spawn_valid;
   logic [COLS*BUF_ROWS-1:0] spawn_pattern;
   logic                     spawn_ready;

   modport master (output spawn_valid, output spawn_pattern, input spawn_ready);
   modport slave  (input spawn_valid, input spawn_pattern, output spawn_ready);

endinterface

// File: rtl/scroll_field_row_popcount.sv
// Saturating accumulate of the number of set bits in one playfield row.
// Only built when SCROLL_FIELD_SCORE_EN is defined.
`ifdef SCROLL_FIELD_SCORE_EN
module row_popcount
   import scroll_field_pkg::*;
#(
   parameter int COLS = 16
) (
   input  logic [COLS-1:0]    row,
   input  logic [SCORE_W-1:0] acc_in,
   output logic [SCORE_W-1:0] acc_out
);

   logic [SCORE_W:0] cnt;
   logic [SCORE_W:0] sum;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < COLS; i++) begin
         cnt = cnt + {{SCORE_W{1'b0}}, row[i]};
      end
      sum     = {1'b0, acc_in} + cnt;
      acc_out = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   end

endmodule
`endif

// File: rtl/scroll_field.sv
// Vertically scrolling obstacle field with hidden spawn buffer, collision and score.
// Score counting is compiled in only with SCROLL_FIELD_SCORE_EN defined.
module scroll_field
   import scroll_field_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 32,
   parameter int BUF_ROWS  = 16,
   parameter int SPEED_DIV = 4
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic                    tick,
   scroll_field_if.slave           spawn,
   input  logic [$clog2(COLS)-1:0] player_col,
   output logic [COLS*ROWS-1:0]    field,
   output logic                    collision,
   output logic [SCORE_W-1:0]      score,
   output logic [1:0]              state
);

   localparam int TOT = BUF_ROWS + ROWS;
   localparam int PCW = $clog2(COLS);
   localparam logic [PCW:0]   COLS_W   = COLS[PCW:0];
   localparam logic [PCW-1:0] LAST_COL = PCW'(COLS - 1);

   state_t                     state_q, state_d;
   logic [COLS-1:0][TOT-1:0]   col_q, col_d, col_upd;
   logic [7:0]                 div_q, div_d;
   logic [SCORE_W-1:0]         score_q, score_d, score_upd;
   logic                       coll_q, coll_d;
   logic [COLS*ROWS-1:0]       field_q, field_d;
   logic [COLS-1:0]            bottom_upd, buf_nz;
   logic                       active, scroll, accept, hit, ready_w;
   logic [PCW-1:0]             pc;

   assign active  = (state_q == RUN) || (state_q == LOAD);
   assign scroll  = active && tick && (div_q == 8'(SPEED_DIV - 1));
   assign ready_w = (state_q == RUN) && !(|buf_nz);
   assign accept  = spawn.spawn_valid && ready_w;
   assign spawn.spawn_ready = ready_w;

   assign pc  = ({1'b0, player_col} >= COLS_W) ? LAST_COL : player_col;
   assign hit = bottom_upd[pc];

   // Row index equals bit index: row 0 (top of buffer) is bit 0, so a scroll is a left shift.
   genvar gi;
   generate
      for (gi = 0; gi < COLS; gi++) begin : g_col
         logic [TOT-1:0] shifted;
         assign shifted     = scroll ? {col_q[gi][TOT-2:0], 1'b0} : col_q[gi];
         assign col_upd[gi] = accept
                            ? (shifted | {{ROWS{1'b0}}, spawn.spawn_pattern[gi*BUF_ROWS +: BUF_ROWS]})
                            : shifted;
         assign bottom_upd[gi] = col_upd[gi][TOT-1];
         assign buf_nz[gi]     = |col_q[gi][BUF_ROWS-1:0];
         assign field_d[gi*ROWS +: ROWS] = col_q[gi][TOT-1:BUF_ROWS];
      end
   endgenerate

`ifdef SCROLL_FIELD_SCORE_EN
   logic [COLS-1:0]    bottom_q;
   logic [SCORE_W-1:0] score_sum;

   generate
      for (gi = 0; gi < COLS; gi++) begin : g_bottom
         assign bottom_q[gi] = col_q[gi][TOT-1];
      end
   endgenerate

   row_popcount #(.COLS(COLS)) u_popcount (
      .row     (bottom_q),
      .acc_in  (score_q),
      .acc_out (score_sum)
   );

   assign score_upd = scroll ? score_sum : score_q;
`else
   assign score_upd = '0;
`endif

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      div_d   = div_q;
      score_d = score_q;
      coll_d  = coll_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               col_d   = '0;
               score_d = '0;
               div_d   = '0;
            end
         end
         RUN, LOAD: begin
            col_d   = col_upd;
            score_d = score_upd;
            if (tick) begin
               div_d = scroll ? 8'd0 : div_q + 8'd1;
            end
            if (hit) begin
               coll_d  = 1'b1;
               state_d = OVER;
            end else if (state_q == LOAD) begin
               state_d = RUN;
            end else if (accept) begin
               state_d = LOAD;
            end
         end
         OVER: begin
            if (start) begin
               state_d = RUN;
               col_d   = '0;
               score_d = '0;
               div_d   = '0;
               coll_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         col_q   <= '0;
         div_q   <= '0;
         score_q <= '0;
         coll_q  <= 1'b0;
         field_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         div_q   <= div_d;
         score_q <= score_d;
         coll_q  <= coll_d;
         field_q <= field_d;
      end
   end

   assign field     = field_q;
   assign collision = coll_q;
   assign score     = score_q;
   assign state     = state_q;

endmodule

// File: doc/scroll_field.md
SCROLL_FIELD -- requirements
Module: scroll_field

Interface
REQ-001 The block SHALL have parameter COLS, default 16, playfield column count.
REQ-002 The block SHALL have parameter ROWS, default 32, visible rows per column.
REQ-003 The block SHALL have parameter BUF_ROWS, default 16, hidden spawn-buffer rows above the visible area.
REQ-004 The block SHALL have parameter SPEED_DIV, default 4, tick pulses per one-row scroll (range 1..255).
REQ-005 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-006 The block SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, one-cycle pulse that leaves IDLE or OVER.
REQ-008 The block SHALL have port tick, input, 1, one-cycle frame pulse.
REQ-009 The block SHALL have port spawn_valid, input, 1, spawn pattern offered.
REQ-010 The block SHALL have port spawn_pattern, input, COLS*BUF_ROWS, bit c*BUF_ROWS+r is column c, buffer row r.
REQ-011 The block SHALL have port spawn_ready, output, 1, pattern can be accepted.
REQ-012 The block SHALL have port player_col, input, $clog2(COLS), player column in the bottom visible row.
REQ-013 The block SHALL have port field, output, COLS*ROWS, bit c*ROWS+r is visible row r of column c, with row 0 at the top.
REQ-014 The block SHALL have port collision, output, 1, sticky collision flag.
REQ-015 The block SHALL have port score, output, 16, count of obstacle bits scrolled off the bottom.
REQ-016 The block SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-017 The block SHALL hold the playfield in an internal array of COLS columns by (BUF_ROWS+ROWS) rows, with buffer rows at indices 0..BUF_ROWS-1.
REQ-018 The block SHALL provide FSM states IDLE=0, RUN=1, LOAD=2 and OVER=3, with the following transitions: IDLE->RUN on start; RUN->LOAD on spawn accept; LOAD->RUN unconditionally after 1 cycle; RUN or LOAD->OVER on collision; OVER->RUN on start, which also clears the array, collision and score.
REQ-019 In IDLE, start SHALL clear the array and score.
REQ-020 The divider SHALL count tick pulses in RUN and LOAD only; when the count reaches SPEED_DIV-1 and tick is high, the block SHALL scroll on that cycle and return the count to 0.
REQ-021 A scroll SHALL move every column down one row, write 0 into row 0, and discard the bottom row.
REQ-022 spawn_ready SHALL be high exactly when state==RUN and all buffer rows are zero.
REQ-023 A spawn is accepted when spawn_valid and spawn_ready are both high; the pattern SHALL be ORed into buffer rows on the accept cycle.
REQ-024 If a spawn accept and a scroll fall on the same cycle, the block SHALL shift first, then OR the pattern into rows 0..BUF_ROWS-1 of the shifted array.
REQ-025 field SHALL be registered and equal to internal rows BUF_ROWS..BUF_ROWS+ROWS-1, one cycle after the array update.
REQ-026 Collision SHALL be asserted when the post-update bottom visible row bit at column player_col is 1; collision is set the next cycle and state moves to OVER in that same cycle.
REQ-027 collision SHALL stay high until reset or start in OVER.
REQ-028 In OVER and IDLE, the array, score and divider SHALL be frozen; tick and spawn_valid are ignored.
REQ-029 A player_col value of COLS or above SHALL be treated as column COLS-1.
REQ-030 score SHALL add, on each scroll, the number of 1 bits in the discarded bottom row, and SHALL saturate at 16'hFFFF.

Reset
REQ-031 When resetn=0 at a clock edge, the block SHALL set state=IDLE, array=0, field=0, divider=0, score=0, collision=0 and spawn_ready=0.
REQ-032 Reset SHALL take priority over start, tick and spawn in any state, including mid-LOAD.

Configuration
REQ-033 With macro SCROLL_FIELD_SCORE_EN defined, the score counter of REQ-030 SHALL be compiled in.
REQ-034 With SCROLL_FIELD_SCORE_EN undefined, score SHALL be tied to 0, no popcount logic SHALL be built, and all other behaviour SHALL be unchanged.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (IDLE, RUN, LOAD, OVER) and the score width constant (16).
REQ-036 The popcount-with-saturation SHALL be a sub-module named row_popcount, parametrised by COLS.

Verification
REQ-037 Test 1: reset, start, SPEED_DIV=4, 8 tick pulses -> exactly 2 scrolls, field stays 0, score=0, state=RUN.
REQ-038 Test 2: spawn_pattern with a single bit at column 3, buffer row 15, accepted while player_col=5, then 32 scrolls -> the bit appears at field bit 3*32+0 after scroll 1, reaches row 31 after scroll 32, score=1 after scroll 33, and collision=0.
REQ-039 Test 3: same as test 2 with player_col=3 -> collision=1 one cycle after scroll 32, state=OVER, and further tick pulses do not change field.
REQ-040 Test 4: spawn_valid held high with a nonzero pattern -> spawn_ready drops the cycle after accept and does not rise again until 16 scrolls have cleared the buffer.
REQ-041 Test 5: a spawn accept coinciding with a scroll -> the old buffer content is shifted one row and the new pattern is ORed in at rows 0..15, with no bits lost.
REQ-042 Test 6: resetn pulsed during LOAD, and a build without SCROLL_FIELD_SCORE_EN -> all outputs match the reset values of REQ-031, and score stays 0 through test 2.
